// File: rtl/mux8_1_us4_1_pkg.sv
// Shared constants and types for the hierarchical 8:1 multiplexer.
// Imported by the RTL and by the bench.
package mux8_1_us4_1_pkg;

    localparam int unsigned NUM_IN  = 8;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned SUB_IN  = NUM_IN / 2;
    localparam int unsigned SUB_SEL = SEL_W - 1;

    typedef logic [SEL_W-1:0]   sel_t;
    typedef logic [SUB_SEL-1:0] sub_sel_t;

    // s[2] picks the upper half (lanes 4..7) of the input vector.
    function automatic logic sel_upper(input sel_t s);
        return s[SEL_W-1];
    endfunction

    function automatic sub_sel_t sel_sub(input sel_t s);
        return s[SUB_SEL-1:0];
    endfunction

endpackage

// File: rtl/mux8_1_us4_1_mux4_1.sv
// Combinational 4:1 lane multiplexer; lane k = i[k*WIDTH +: WIDTH].
module mux4_1 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [4*WIDTH-1:0] i,
    input  logic [1:0]         s,
    output logic [WIDTH-1:0]   y
);

    always_comb begin
        y = '0;
        unique case (s)
            2'd0: y = i[0*WIDTH +: WIDTH];
            2'd1: y = i[1*WIDTH +: WIDTH];
            2'd2: y = i[2*WIDTH +: WIDTH];
            2'd3: y = i[3*WIDTH +: WIDTH];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mux8_1_us4_1.sv
// 8:1 multiplexer from two mux4_1 halves plus a 2:1 stage, with a registered copy.
// Define MUX8_1_US4_1_HOLD_EN to add the en load-enable port on the y_q register.
module mux8_1_us4_1
    import mux8_1_us4_1_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef MUX8_1_US4_1_HOLD_EN
    input  logic                    en,
`endif
    input  logic [NUM_IN*WIDTH-1:0] i,
    input  logic [SEL_W-1:0]        s,
    output logic [WIDTH-1:0]        y,
    output logic [WIDTH-1:0]        y_q
);

    logic [WIDTH-1:0] y_lower;
    logic [WIDTH-1:0] y_upper;
    sub_sel_t         s_sub;

    assign s_sub = sel_sub(s);

    mux4_1 #(
        .WIDTH (WIDTH)
    ) u_mux_lower (
        .i (i[SUB_IN*WIDTH-1:0]),
        .s (s_sub),
        .y (y_lower)
    );

    mux4_1 #(
        .WIDTH (WIDTH)
    ) u_mux_upper (
        .i (i[NUM_IN*WIDTH-1:SUB_IN*WIDTH]),
        .s (s_sub),
        .y (y_upper)
    );

    always_comb begin
        y = y_lower;
        if (sel_upper(s)) begin
            y = y_upper;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
        end else begin
`ifdef MUX8_1_US4_1_HOLD_EN
            if (en) begin
                y_q <= y;
            end
`else
            y_q <= y;
`endif
        end
    end

endmodule

// File: tb/tb_mux8_1_us4_1.sv
// Directed-vector bench for mux8_1_us4_1 at WIDTH=1 and WIDTH=4.
`timescale 1ns/1ps
module tb_mux8_1_us4_1;
    import mux8_1_us4_1_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
`ifdef MUX8_1_US4_1_HOLD_EN
    logic        en  = 1'b1;
`endif
    logic [7:0]  i1  = '0;
    sel_t        s1  = '0;
    logic        y1;
    logic        yq1;
    logic [31:0] i4  = '0;
    sel_t        s4  = '0;
    logic [3:0]  y4;
    logic [3:0]  yq4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux8_1_us4_1 #(
        .WIDTH (1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
`ifdef MUX8_1_US4_1_HOLD_EN
        .en  (en),
`endif
        .i   (i1),
        .s   (s1),
        .y   (y1),
        .y_q (yq1)
    );

    mux8_1_us4_1 #(
        .WIDTH (4)
    ) dut4 (
        .clk (clk),
        .rst (rst),
`ifdef MUX8_1_US4_1_HOLD_EN
        .en  (en),
`endif
        .i   (i4),
        .s   (s4),
        .y   (y4),
        .y_q (yq4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        // Async reset with no clock edge in between.
        #1 rst = 1'b1;
        #1;
        check_eq("rst_yq1", 32'(yq1), 32'd0);
        check_eq("rst_yq4", 32'(yq4), 32'd0);
        i1 = 8'hFF;
        s1 = 3'd5;
        #1;
        check_eq("rst_y_unaffected", 32'(y1), 32'd1);
        @(posedge clk);
        #1;
        check_eq("rst_held", 32'(yq1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("before_first_edge", 32'(yq1), 32'd0);
        @(posedge clk);
        #1;
        check_eq("first_load", 32'(yq1), 32'd1);

        // Mid-run async reset between edges.
        #2 rst = 1'b1;
        #1;
        check_eq("midrun_rst_yq", 32'(yq1), 32'd0);
        check_eq("midrun_rst_y", 32'(y1), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Walking one, 10-unit steps.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            i1 = 8'd1 << k;
            s1 = sel_t'(k);
            #1;
            check_eq($sformatf("walk1_s%0d", k), 32'(y1), 32'd1);
        end

        // Unselected lanes must not leak through.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            i1 = ~(8'd1 << k);
            s1 = sel_t'(k);
            #1;
            check_eq($sformatf("walk0_s%0d", k), 32'(y1), 32'd0);
        end

        @(negedge clk);
        i1 = 8'b00000100;
        s1 = 3'd3;
        #1;
        check_eq("mismatch_s3", 32'(y1), 32'd0);
        s1 = 3'd2;
        #1;
        check_eq("match_s2", 32'(y1), 32'd1);

        // WIDTH=4, lane k = k+8, y_q follows one edge later.
        i4 = {4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s4 = sel_t'(k);
            #1;
            check_eq($sformatf("w4_y_s%0d", k), 32'(y4), 32'(k + 8));
            @(posedge clk);
            #1;
            check_eq($sformatf("w4_yq_s%0d", k), 32'(yq4), 32'(k + 8));
        end

`ifdef MUX8_1_US4_1_HOLD_EN
        @(negedge clk);
        i1 = 8'hFF;
        s1 = 3'd0;
        en = 1'b1;
        @(posedge clk);
        #1;
        check_eq("en_load_one", 32'(yq1), 32'd1);
        @(negedge clk);
        en = 1'b0;
        i1 = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("en_hold_%0d", k), 32'(yq1), 32'd1);
            @(negedge clk);
            i1 = ~i1;
            #1;
            i1 = 8'h00;
        end
        #1;
        check_eq("en_y_live", 32'(y1), 32'd0);
        en = 1'b1;
        @(posedge clk);
        #1;
        check_eq("en_update", 32'(yq1), 32'd0);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("en_rst_clears", 32'(yq4), 32'd0);
        rst = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
